// File: rtl/decode_stage_if.sv
// Decode-stage bus: instruction in from IF/ID, decoded fields and operands out to ID/EX.
interface decode_stage_if;
    logic [31:0] Instruction;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        MemToReg;
    logic [2:0]  ALUOp;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] immediate64bit;
    logic [2:0]  funct3;
    logic [2:0]  I_Type;
    logic [31:0] rs1Out;
    logic [31:0] rs2Out;

    // IF/ID side: supplies the instruction, consumes the decode results
    modport master (
        output Instruction,
        input  RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, ALUOp,
        input  rd, rs1, rs2, immediate64bit, funct3, I_Type, rs1Out, rs2Out
    );

    // Decode stage side
    modport slave (
        input  Instruction,
        output RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, ALUOp,
        output rd, rs1, rs2, immediate64bit, funct3, I_Type, rs1Out, rs2Out
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 instruction decode: combinational control/immediate decode plus a
// 32x32 register file with two asynchronous read ports. The register file
// has no write port; reset loads xi = i.
module decode_stage (
    input  logic          clk_i,
    input  logic          reset_i,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_BR   = 3'b001;
    localparam logic [2:0] ALU_RTY  = 3'b010;
    localparam logic [2:0] ALU_ITY  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_LINK = 3'b101;

    // Immediate extraction, each sign-extended from bit 31 to 64 bits
    function automatic logic signed [63:0] imm_i(input logic [31:0] ins);
        logic signed [11:0] f;
        f = ins[31:20];
        return 64'(f);
    endfunction

    function automatic logic signed [63:0] imm_s(input logic [31:0] ins);
        logic signed [11:0] f;
        f = {ins[31:25], ins[11:7]};
        return 64'(f);
    endfunction

    function automatic logic signed [63:0] imm_b(input logic [31:0] ins);
        logic signed [12:0] f;
        f = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return 64'(f);
    endfunction

    function automatic logic signed [63:0] imm_u(input logic [31:0] ins);
        logic signed [31:0] f;
        f = {ins[31:12], 12'b0};
        return 64'(f);
    endfunction

    function automatic logic signed [63:0] imm_j(input logic [31:0] ins);
        logic signed [20:0] f;
        f = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return 64'(f);
    endfunction

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;

    assign ins     = bus.Instruction;
    assign opcode  = ins[6:0];
    assign rs1_idx = ins[19:15];
    assign rs2_idx = ins[24:20];

    logic               dec_regwrite;
    logic               dec_memread;
    logic               dec_memwrite;
    logic               dec_alusrc;
    logic               dec_memtoreg;
    logic [2:0]         dec_aluop;
    logic [2:0]         dec_fmt;
    logic signed [63:0] dec_imm;

    logic [31:0] regs [32];
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    // Register file: reload xi = i on every reset edge, hold otherwise
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end
    end

    // Opcode decode to control tuple, ALU class and instruction format
    always_comb begin
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_aluop    = ALU_ADD;
        dec_fmt      = FMT_R;
        unique case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_aluop    = ALU_RTY;
                dec_fmt      = FMT_R;
            end
            OP_I: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_ITY;
                dec_fmt      = FMT_I;
            end
            OP_LOAD: begin
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_fmt      = FMT_I;
            end
            OP_STORE: begin
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_fmt      = FMT_S;
            end
            OP_BRANCH: begin
                dec_aluop    = ALU_BR;
                dec_fmt      = FMT_B;
            end
            OP_LUI: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_PASS;
                dec_fmt      = FMT_U;
            end
            OP_AUIPC: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_fmt      = FMT_U;
            end
            OP_JAL: begin
                dec_regwrite = 1'b1;
                dec_aluop    = ALU_LINK;
                dec_fmt      = FMT_J;
            end
            OP_JALR: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_LINK;
                dec_fmt      = FMT_I;
            end
            default: begin
                // Unknown opcode is a bubble: everything stays at zero
                dec_aluop    = ALU_ADD;
                dec_fmt      = FMT_R;
            end
        endcase
    end

    // Immediate selection; R-type and bubbles carry no immediate
    always_comb begin
        dec_imm = '0;
        unique case (opcode)
            OP_I, OP_LOAD, OP_JALR: dec_imm = imm_i(ins);
            OP_STORE:               dec_imm = imm_s(ins);
            OP_BRANCH:              dec_imm = imm_b(ins);
            OP_LUI, OP_AUIPC:       dec_imm = imm_u(ins);
            OP_JAL:                 dec_imm = imm_j(ins);
            default:                dec_imm = '0;
        endcase
    end

    // Asynchronous register reads; x0 is hard-wired to zero
    always_comb begin
        rs1_data = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
        rs2_data = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];
    end

    // Raw instruction fields pass through even during reset
    assign bus.rd     = ins[11:7];
    assign bus.rs1    = rs1_idx;
    assign bus.rs2    = rs2_idx;
    assign bus.funct3 = ins[14:12];

    // Output drive: everything except the raw fields is held at zero in reset
    always_comb begin
        bus.RegWrite       = 1'b0;
        bus.MemRead        = 1'b0;
        bus.MemWrite       = 1'b0;
        bus.ALUSrc         = 1'b0;
        bus.MemToReg       = 1'b0;
        bus.ALUOp          = 3'b000;
        bus.I_Type         = 3'd0;
        bus.immediate64bit = 64'd0;
        bus.rs1Out         = 32'd0;
        bus.rs2Out         = 32'd0;
        if (!reset_i) begin
            bus.RegWrite       = dec_regwrite;
            bus.MemRead        = dec_memread;
            bus.MemWrite       = dec_memwrite;
            bus.ALUSrc         = dec_alusrc;
            bus.MemToReg       = dec_memtoreg;
            bus.ALUOp          = dec_aluop;
            bus.I_Type         = dec_fmt;
            bus.immediate64bit = dec_imm;
            bus.rs1Out         = rs1_data;
            bus.rs2Out         = rs2_data;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven reference model checked every cycle,
// plus hand-computed expectations for the directed instruction vectors.
module tb_decode_stage;

    logic clk;
    logic reset_i;
    decode_stage_if bus ();

    decode_stage dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Control row: opcode, {RegWrite,MemRead,MemWrite,ALUSrc,MemToReg}, ALUOp, format
    typedef struct packed {
        logic [6:0] op;
        logic [4:0] ctl;
        logic [2:0] aluop;
        logic [2:0] fmt;
    } row_t;

    row_t tbl [9] = '{
        '{7'b0110011, 5'b10000, 3'b010, 3'd0},
        '{7'b0010011, 5'b10010, 3'b011, 3'd1},
        '{7'b0000011, 5'b11011, 3'b000, 3'd1},
        '{7'b0100011, 5'b00110, 3'b000, 3'd2},
        '{7'b1100011, 5'b00000, 3'b001, 3'd3},
        '{7'b0110111, 5'b10010, 3'b100, 3'd4},
        '{7'b0010111, 5'b10010, 3'b000, 3'd4},
        '{7'b1101111, 5'b10000, 3'b101, 3'd5},
        '{7'b1100111, 5'b10010, 3'b101, 3'd1}
    };

    typedef struct {
        logic [4:0]  ctl;
        logic [2:0]  aluop;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } exp_t;

    int unsigned rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = i;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        bit hit;
        e.ctl = '0; e.aluop = '0; e.fmt = '0; e.imm = '0;
        hit = 1'b0;
        foreach (tbl[k]) begin
            if (tbl[k].op == ins[6:0]) begin
                e.ctl = tbl[k].ctl; e.aluop = tbl[k].aluop; e.fmt = tbl[k].fmt;
                hit = 1'b1;
            end
        end
        if (hit) begin
            case (e.fmt)
                3'd1: e.imm = longint'($signed(ins[31:20]));
                3'd2: e.imm = longint'($signed({ins[31:25], ins[11:7]}));
                3'd3: e.imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                3'd4: e.imm = longint'($signed({ins[31:12], 12'b0}));
                3'd5: e.imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                default: e.imm = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs must equal the model (or the forced zeros in reset)
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] ins;
            exp_t e;
            ins = bus.Instruction;
            e = model(ins);
            check("rd",     64'(bus.rd),     64'(ins[11:7]));
            check("rs1",    64'(bus.rs1),    64'(ins[19:15]));
            check("rs2",    64'(bus.rs2),    64'(ins[24:20]));
            check("funct3", 64'(bus.funct3), 64'(ins[14:12]));
            if (reset_i) begin
                e.ctl = '0; e.aluop = '0; e.fmt = '0; e.imm = '0;
            end
            check("ctl", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.MemToReg}),
                  64'(e.ctl));
            check("ALUOp",  64'(bus.ALUOp),  64'(e.aluop));
            check("I_Type", 64'(bus.I_Type), 64'(e.fmt));
            check("imm",    bus.immediate64bit, e.imm);
            check("rs1Out", 64'(bus.rs1Out),
                  reset_i ? 64'd0 : (ins[19:15] == 0 ? 64'd0 : 64'(rf[ins[19:15]])));
            check("rs2Out", 64'(bus.rs2Out),
                  reset_i ? 64'd0 : (ins[24:20] == 0 ? 64'd0 : 64'(rf[ins[24:20]])));
        end
    end

    task automatic apply(input logic [31:0] ins);
        @(posedge clk);
        #1 bus.Instruction = ins;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1;
        bus.Instruction = 32'h001181B3;
        #1 chk_en = 1'b1;
        #1;
        check("lit_rst_regwrite", 64'(bus.RegWrite), 64'd0);
        check("lit_rst_rs1Out",   64'(bus.rs1Out),   64'd0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        #1;
        // add: fields 31..7 give rd=3, rs1=3, rs2=1
        check("lit_add_ctl", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.MemToReg}), 64'b10000);
        check("lit_add_aluop", 64'(bus.ALUOp), 64'b010);
        check("lit_add_rd", 64'(bus.rd), 64'd3);
        check("lit_add_rs1Out", 64'(bus.rs1Out), 64'd3);
        check("lit_add_rs2Out", 64'(bus.rs2Out), 64'd1);
        check("lit_add_imm", bus.immediate64bit, 64'd0);

        apply(32'h0040A1A3);
        check("lit_sw_ctl", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.MemToReg}), 64'b00110);
        check("lit_sw_fmt", 64'(bus.I_Type), 64'd2);
        check("lit_sw_funct3", 64'(bus.funct3), 64'b010);
        check("lit_sw_imm", bus.immediate64bit, 64'd3);
        check("lit_sw_rs1Out", 64'(bus.rs1Out), 64'd1);
        check("lit_sw_rs2Out", 64'(bus.rs2Out), 64'd4);

        apply(32'h00008563);
        check("lit_beq_aluop", 64'(bus.ALUOp), 64'b001);
        check("lit_beq_fmt", 64'(bus.I_Type), 64'd3);
        check("lit_beq_imm", bus.immediate64bit, 64'd10);
        check("lit_beq_rs2Out", 64'(bus.rs2Out), 64'd0);

        apply(32'h0143E293);
        check("lit_ori_aluop", 64'(bus.ALUOp), 64'b011);
        check("lit_ori_funct3", 64'(bus.funct3), 64'b110);
        check("lit_ori_rd", 64'(bus.rd), 64'd5);
        check("lit_ori_imm", bus.immediate64bit, 64'd20);
        check("lit_ori_rs1Out", 64'(bus.rs1Out), 64'd7);
        check("lit_ori_rs2Out", 64'(bus.rs2Out), 64'd20);

        apply(32'hFFF00093);
        check("lit_addi_imm", bus.immediate64bit, 64'hFFFF_FFFF_FFFF_FFFF);

        apply(32'h0000A003);
        check("lit_lw_memread", 64'(bus.MemRead), 64'd1);
        check("lit_lw_memtoreg", 64'(bus.MemToReg), 64'd1);

        apply(32'h800000B7);
        check("lit_lui_imm", bus.immediate64bit, 64'hFFFF_FFFF_8000_0000);
        check("lit_lui_fmt", 64'(bus.I_Type), 64'd4);
        check("lit_lui_aluop", 64'(bus.ALUOp), 64'b100);

        apply(32'hFE000FE3);
        check("lit_bneg_imm", bus.immediate64bit, 64'hFFFF_FFFF_FFFF_FFFE);

        apply(32'h008000EF);
        check("lit_jal_imm", bus.immediate64bit, 64'd8);
        check("lit_jal_aluop", 64'(bus.ALUOp), 64'b101);

        apply(32'h12345297);
        check("lit_auipc_imm", bus.immediate64bit, 64'h0000_0000_1234_5000);

        apply(32'hABCDE000);
        check("lit_bubble_imm", bus.immediate64bit, 64'd0);
        check("lit_bubble_regwrite", 64'(bus.RegWrite), 64'd0);

        // Every opcode value, including all the bubbles, against the model
        for (int op = 0; op < 128; op++) apply(32'h8BCD5F80 | 32'(op));

        // Every register on both read ports
        for (int r = 0; r < 32; r++) apply({7'd0, 5'(31 - r), 5'(r), 3'd0, 5'd1, 7'b0110011});

        // Mid-stream reset: outputs forced, raw fields kept, decode resumes on release
        apply(32'hFFF00093);
        reset_i = 1'b1;
        #1;
        check("lit_mid_rst_imm", bus.immediate64bit, 64'd0);
        check("lit_mid_rst_rd", 64'(bus.rd), 64'd1);
        apply(32'h0143E293);
        check("lit_mid_rst_rs1Out", 64'(bus.rs1Out), 64'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        #1;
        check("lit_after_rst_imm", bus.immediate64bit, 64'd20);
        check("lit_after_rst_rs1Out", 64'(bus.rs1Out), 64'd7);

        apply(32'h001181B3);
        apply(32'h00000000);
        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
